// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - register-file writeback FIFO with pending-write mask
//
// Buffers {rd, data} results from execute/memory and drains one per cycle into
// the register file write port. Writes to $0 are accepted and discarded.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_rd/in_data carry the result
//   wb_enable           1 = drain permitted this cycle, 0 = stall
//   RegWrite            registered write strobe, one cycle per entry
//   WriteRegister       registered write address
//   WriteData_reg       registered write data
//   busy_mask           bit r set while a write to r is queued or on the port
//   count               queued entries, excluding the output stage
//   empty               nothing queued and nothing on the port

module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_enable,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData_reg,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              accept;
    logic              push;
    logic              pop;

    // Full-queue refusal ignores the same-cycle pop so in_ready has no
    // combinational path from wb_enable.
    assign in_ready = !reset && (count < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    // $0 transfers complete the handshake but never occupy a slot.
    assign push     = accept && (in_rd != '0);
    assign pop      = wb_enable && (count != '0);

    assign empty    = (count == '0) && !RegWrite;

    // Storage needs no reset: validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_rd[tail]   <= in_rd;
            mem_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData_reg <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end

            // No bypass: only entries already stored before this edge drain.
            if (pop) begin
                RegWrite      <= 1'b1;
                WriteRegister <= mem_rd[head];
                WriteData_reg <= mem_data[head];
                head          <= head + PTR_W'(1);
            end else begin
                RegWrite      <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    logic [PTR_W-1:0] rel [DEPTH];
    logic [DEPTH-1:0] live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rel[i]  = PTR_W'(i) - head;
            live[i] = ({1'b0, rel[i]} < count);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                busy_mask = busy_mask | (32'd1 << mem_rd[i]);
            end
        end
        if (RegWrite) begin
            busy_mask = busy_mask | (32'd1 << WriteRegister);
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - self-checking bench for regfile_writeback_queue

module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        wb_enable;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData_reg;
    logic [31:0] busy_mask;
    logic [2:0]  count;
    logic        empty;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .wb_enable     (wb_enable),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData_reg (WriteData_reg),
        .busy_mask     (busy_mask),
        .count         (count),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending writes in acceptance order plus the port state.
    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    logic        obs_ready;
    logic        exp_ready;
    logic        accepted;

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        if (m_rw) m[m_wreg] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: apply inputs at negedge, advance the model at posedge,
    // return 1 ns after the edge so outputs can be sampled.
    task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic wbe, input logic rst);
        logic pop;
        @(negedge clk);
        in_valid  = v;
        in_rd     = rd;
        in_data   = d;
        wb_enable = wbe;
        reset     = rst;
        #1;
        obs_ready = in_ready;
        exp_ready = !rst && (mq.size() < DEPTH);
        accepted  = v && exp_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rw    = 1'b0;
            m_wreg  = '0;
            m_wdata = '0;
        end else begin
            pop = wbe && (mq.size() > 0);
            if (pop) begin
                ent_t e;
                e       = mq.pop_front();
                m_rw    = 1'b1;
                m_wreg  = e.rd;
                m_wdata = e.data;
            end else begin
                m_rw = 1'b0;
            end
            if (accepted && rd != 5'd0) mq.push_back('{rd: rd, data: d});
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 5'd3, 32'h1234, 1'b1, 1'b1);
        checks++;
        if (obs_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", obs_ready); end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", RegWrite); end
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (busy_mask !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++;
        if (WriteRegister !== 5'd0 || WriteData_reg !== 32'h0) begin
            failures++; $display("FAIL reset_port got=%0d/%h exp=0/0", WriteRegister, WriteData_reg);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_single_write();
        cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b0 || busy_mask[7] !== 1'b1 || count !== 3'd1) begin
            failures++; $display("FAIL single_edge1 rw=%0b busy7=%0b count=%0d exp rw=0 busy7=1 count=1", RegWrite, busy_mask[7], count);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData_reg !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_edge2 rw=%0b rd=%0d data=%h exp rw=1 rd=7 data=deadbeef", RegWrite, WriteRegister, WriteData_reg);
        end
        checks++;
        if (busy_mask !== 32'h80) begin failures++; $display("FAIL single_busy2 got=%h exp=80", busy_mask); end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b0 || busy_mask !== 32'h0 || empty !== 1'b1) begin
            failures++; $display("FAIL single_edge3 rw=%0b busy=%h empty=%0b exp rw=0 busy=0 empty=1", RegWrite, busy_mask, empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'(i * 32'h11), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || busy_mask !== 32'h1E) begin
            failures++; $display("FAIL fill_full count=%0d ready=%0b busy=%h exp count=4 ready=0 busy=1e", count, in_ready, busy_mask);
        end
        // Full queue refuses input even while draining.
        cycle(1'b1, 5'd20, 32'hBAD, 1'b1, 1'b0);
        checks++;
        if (obs_ready !== 1'b0) begin failures++; $display("FAIL fill_refuse got=%0b exp=0", obs_ready); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData_reg !== 32'(i * 32'h11)) begin
                failures++; $display("FAIL fill_drain%0d rw=%0b rd=%0d data=%h exp rw=1 rd=%0d data=%h", i, RegWrite, WriteRegister, WriteData_reg, i, i * 32'h11);
            end
            if (i < 4) cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1 || RegWrite !== 1'b0) begin failures++; $display("FAIL fill_empty empty=%0b rw=%0b exp 1/0", empty, RegWrite); end
    endtask

    task automatic test_zero_drop();
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || count !== 3'd0 || busy_mask !== 32'h0) begin
            failures++; $display("FAIL zero_accept ready=%0b count=%0d busy=%h exp 1/0/0", obs_ready, count, busy_mask);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b0 || in_ready !== 1'b1 || empty !== 1'b1) begin
            failures++; $display("FAIL zero_nowrite rw=%0b ready=%0b empty=%0b exp 0/1/1", RegWrite, in_ready, empty);
        end
    endtask

    task automatic test_same_reg();
        cycle(1'b1, 5'd9, 32'h1, 1'b1, 1'b0);
        checks++;
        if (busy_mask[9] !== 1'b1) begin failures++; $display("FAIL same_busy1 got=%0b exp=1", busy_mask[9]); end
        cycle(1'b1, 5'd9, 32'h2, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData_reg !== 32'h1 || busy_mask[9] !== 1'b1) begin
            failures++; $display("FAIL same_first rw=%0b rd=%0d data=%h busy9=%0b exp 1/9/1/1", RegWrite, WriteRegister, WriteData_reg, busy_mask[9]);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData_reg !== 32'h2 || busy_mask[9] !== 1'b1) begin
            failures++; $display("FAIL same_second rw=%0b rd=%0d data=%h busy9=%0b exp 1/9/2/1", RegWrite, WriteRegister, WriteData_reg, busy_mask[9]);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b0 || busy_mask !== 32'h0) begin failures++; $display("FAIL same_clear rw=%0b busy=%h exp 0/0", RegWrite, busy_mask); end
    endtask

    task automatic test_wraparound();
        logic        pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ent_t        sent[$];
        ent_t        seen[$];
        int          n = 0;
        int          cyc = 0;
        logic [4:0]  rd;
        logic [31:0] d;
        while ((n < 10 || !empty) && cyc < 200) begin
            rd = 5'(1 + (n % 31));
            d  = $urandom;
            cycle(n < 10, rd, d, (n < 10) ? pattern[cyc % 5] : 1'b1, 1'b0);
            if (n < 10 && accepted) begin sent.push_back('{rd: rd, data: d}); n++; end
            if (RegWrite) seen.push_back('{rd: WriteRegister, data: WriteData_reg});
            checks++;
            if (count > 3'd4) begin failures++; $display("FAIL wrap_count got=%0d exp<=4", count); end
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin failures++; $display("FAIL wrap_timeout cycles=%0d exp<200", cyc); end
        checks++;
        if (seen.size() != 10) begin failures++; $display("FAIL wrap_total got=%0d exp=10", seen.size()); end
        for (int i = 0; i < 10 && i < seen.size() && i < sent.size(); i++) begin
            checks++;
            if (seen[i] !== sent[i]) begin
                failures++; $display("FAIL wrap_order%0d got=%0d/%h exp=%0d/%h", i, seen[i].rd, seen[i].data, sent[i].rd, sent[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL mid_setup rw=%0b count=%0d exp 1/3", RegWrite, count); end
        cycle(1'b1, 5'd5, 32'h77, 1'b1, 1'b1);
        checks++;
        if (RegWrite !== 1'b0 || count !== 3'd0 || busy_mask !== 32'h0) begin
            failures++; $display("FAIL mid_reset rw=%0b count=%0d busy=%h exp 0/0/0", RegWrite, count, busy_mask);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (RegWrite !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL mid_stale%0d rw=%0b empty=%0b exp 0/1", i, RegWrite, empty); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, 5'($urandom % 8), $urandom, ($urandom % 3) != 0, ($urandom % 97) == 0);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_ready%0d got=%0b exp=%0b", i, obs_ready, exp_ready); end
            checks++;
            if (RegWrite !== m_rw || WriteRegister !== m_wreg || WriteData_reg !== m_wdata) begin
                failures++; $display("FAIL rand_port%0d got=%0b/%0d/%h exp=%0b/%0d/%h", i, RegWrite, WriteRegister, WriteData_reg, m_rw, m_wreg, m_wdata);
            end
            checks++;
            if (count !== 3'(mq.size()) || busy_mask !== model_mask() || empty !== (mq.size() == 0 && !m_rw)) begin
                failures++; $display("FAIL rand_state%0d count=%0d busy=%h empty=%0b exp %0d/%h/%0b", i, count, busy_mask, empty, mq.size(), model_mask(), (mq.size() == 0 && !m_rw));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rd     = '0;
        in_data   = '0;
        wb_enable = 1'b0;
        m_rw      = 1'b0;
        m_wreg    = '0;
        m_wdata   = '0;
        test_reset();
        test_single_write();
        test_fill();
        test_zero_drop();
        test_same_reg();
        test_wraparound();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
